// File: rtl/prog_mem_loader_pkg.sv
// Shared defaults and state encoding for the program-memory loader.
package prog_mem_loader_pkg;

    localparam int unsigned ADR_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Program storage: one synchronous write port, one asynchronous read port.
module mem_array #(
    parameter int unsigned ADR_W  = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADR_W-1:0]  wadr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADR_W-1:0]  radr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wadr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[radr_i];

endmodule

// File: rtl/prog_mem_loader.sv
// Streams a program image into memory while holding the CPU in reset, then
// hands the memory to the CPU bus with zero-wait-state reads.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned ADR_W  = ADR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr_bus,
    input  logic              rd_mem,
    input  logic              wr_mem,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_skip,
    output logic              load_ready,
    output logic              cpu_reset,
    output logic [ADR_W:0]    words_loaded,
    output logic              bus_err
);

    localparam int unsigned CNT_W = ADR_W + 1;

    state_e             state_q, state_d;
    logic [ADR_W-1:0]   load_adr_q, load_adr_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               bus_err_q, bus_err_d;
    logic               cpu_reset_q;

    logic               mem_we;
    logic [ADR_W-1:0]   mem_wadr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    // Next-state and write-port mux: loader owns the port in LOAD, CPU in RUN.
    always_comb begin
        state_d    = state_q;
        load_adr_d = load_adr_q;
        words_d    = words_q;
        bus_err_d  = bus_err_q;
        mem_we     = 1'b0;
        mem_wadr   = load_adr_q;
        mem_wdata  = load_data;

        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we     = 1'b1;
                    load_adr_d = load_adr_q + ADR_W'(1);
                    words_d    = words_q + CNT_W'(1);
                    if (load_last || load_skip || (load_adr_q == {ADR_W{1'b1}})) begin
                        state_d = ST_RUN;
                    end
                end else if (load_skip) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A simultaneous read and write is a CPU bus fault; the read wins.
                if (rd_mem && wr_mem) begin
                    bus_err_d = 1'b1;
                end else if (wr_mem) begin
                    mem_we    = 1'b1;
                    mem_wadr  = adr_bus;
                    mem_wdata = data_bus;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            load_adr_q  <= '0;
            words_q     <= '0;
            bus_err_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            load_adr_q  <= load_adr_d;
            words_q     <= words_d;
            bus_err_q   <= bus_err_d;
            // Lags the state by one edge so the CPU sees a full reset cycle after the last write.
            cpu_reset_q <= (state_q == ST_LOAD);
        end
    end

    mem_array #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we && !reset),
        .wadr_i  (mem_wadr),
        .wdata_i (mem_wdata),
        .radr_i  (adr_bus),
        .rdata_o (mem_rdata)
    );

    assign data_bus     = ((state_q == ST_RUN) && rd_mem) ? mem_rdata : {DATA_W{1'bz}};
    assign load_ready   = (state_q == ST_LOAD);
    assign cpu_reset    = cpu_reset_q;
    assign words_loaded = words_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed and randomized checks of prog_mem_loader against a behavioural model.
module tb_prog_mem_loader;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk;
    logic          reset;
    logic [AW-1:0] adr_bus;
    logic          rd_mem;
    logic          wr_mem;
    wire  [DW-1:0] data_bus;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_skip;
    logic          load_ready;
    logic          cpu_reset;
    logic [AW:0]   words_loaded;
    logic          bus_err;

    logic          tb_en;
    logic [DW-1:0] tb_drv;

    prog_mem_loader #(.ADR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .adr_bus      (adr_bus),
        .rd_mem       (rd_mem),
        .wr_mem       (wr_mem),
        .data_bus     (data_bus),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_skip    (load_skip),
        .load_ready   (load_ready),
        .cpu_reset    (cpu_reset),
        .words_loaded (words_loaded),
        .bus_err      (bus_err)
    );

    assign data_bus = tb_en ? tb_drv : {DW{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_val [DEPTH];
    bit            m_run   = 1'b0;
    int            m_adr   = 0;
    int            m_words = 0;
    bit            m_err   = 1'b0;
    bit            m_cpu   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the rules for the coming edge to the model, then advance one clock.
    task automatic tick();
        bit was_run;
        was_run = m_run;
        if (reset) begin
            m_run = 1'b0; m_adr = 0; m_words = 0; m_err = 1'b0; m_cpu = 1'b1;
        end else begin
            m_cpu = !was_run;
            if (!m_run) begin
                if (load_valid) begin
                    m_mem[m_adr] = load_data;
                    m_val[m_adr] = 1'b1;
                    m_words++;
                    m_adr++;
                    if (load_last || load_skip || m_adr == DEPTH) m_run = 1'b1;
                end else if (load_skip) begin
                    m_run = 1'b1;
                end
            end else if (rd_mem && wr_mem) begin
                m_err = 1'b1;
            end else if (wr_mem) begin
                m_mem[adr_bus] = tb_drv;
                m_val[adr_bus] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(!m_run));
        chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(m_cpu));
        chk({tag, ".words"}, 32'(words_loaded), 32'(m_words));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_err));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic load_byte(input logic [DW-1:0] d, input bit last, input bit skip);
        load_valid = 1'b1; load_data = d; load_last = last; load_skip = skip;
        tick();
        load_valid = 1'b0; load_last = 1'b0; load_skip = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int adr);
        rd_mem = 1'b1; wr_mem = 1'b0; tb_en = 1'b0; adr_bus = AW'(adr);
        #1;
        chk(tag, 32'(data_bus), 32'(m_mem[adr]));
        tick();
        rd_mem = 1'b0;
    endtask

    // Bench drives zeros; any DUT drive of nonzero data disturbs the bus.
    task automatic hz_chk(input string tag, input int adr, input bit rd);
        rd_mem = rd; wr_mem = 1'b0; tb_en = 1'b1; tb_drv = '0; adr_bus = AW'(adr);
        #1;
        chk(tag, 32'(data_bus), 32'h0);
        tb_en = 1'b0; rd_mem = 1'b0;
    endtask

    task automatic cpu_wr(input int adr, input logic [DW-1:0] d);
        wr_mem = 1'b1; rd_mem = 1'b0; tb_en = 1'b1; tb_drv = d; adr_bus = AW'(adr);
        tick();
        wr_mem = 1'b0; tb_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] b;
        int a;
        reset = 1'b1; adr_bus = '0; rd_mem = 1'b0; wr_mem = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; load_skip = 1'b0;
        tb_en = 1'b0; tb_drv = '0;

        // Reset state
        do_reset(2);
        check_state("reset");

        // Three-byte image with load_last; CPU strobes ignored during LOAD
        load_byte(8'h11, 1'b0, 1'b0);
        hz_chk("load_hz0", 0, 1'b1);
        load_byte(8'h22, 1'b0, 1'b0);
        load_byte(8'h33, 1'b1, 1'b0);
        check_state("load3_run");
        chk("load3_cpu_reset_held", 32'(cpu_reset), 32'h1);
        tick();
        check_state("load3_plus1");
        rd_chk("rd_adr2", 2);
        rd_chk("rd_adr0", 0);
        rd_chk("rd_adr1", 1);

        // CPU write then read back, and undriven bus when idle
        cpu_wr(5, 8'hA5);
        rd_chk("rd_adr5", 5);
        hz_chk("idle_hz", 5, 1'b0);

        // Randomized CPU traffic above the preloaded image
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                cpu_wr(int'($urandom_range(DEPTH - 1, 3)), DW'($urandom));
            end else begin
                a = int'($urandom_range(DEPTH - 1, 0));
                while (!m_val[a]) a = (a + 1) % DEPTH;
                rd_chk("rand_rd", a);
            end
        end
        check_state("rand_run");

        // Read and write together: read wins, write suppressed, error sticks
        rd_mem = 1'b1; wr_mem = 1'b1; tb_en = 1'b0; adr_bus = AW'(2);
        #1;
        chk("conflict_rd", 32'(data_bus), 32'h33);
        tick();
        rd_mem = 1'b0; wr_mem = 1'b0;
        check_state("conflict");
        rd_chk("conflict_mem2", 2);
        tick(); tick();
        chk("bus_err_sticky", 32'(bus_err), 32'h1);

        // Reset mid-RUN, then skip straight back to the retained image
        do_reset(1);
        check_state("rerun_reset");
        load_skip = 1'b1;
        tick();
        load_skip = 1'b0;
        check_state("skip_run");
        tick();
        check_state("skip_plus1");
        rd_chk("skip_mem0", 0);

        // Reset after two of four bytes restarts at address 0
        do_reset(1);
        for (int i = 0; i < 2; i++) begin
            load_byte(DW'($urandom), 1'b0, 1'b0);
            check_state("partial");
        end
        do_reset(1);
        check_state("partial_reset");
        for (int i = 0; i < 4; i++) begin
            load_byte(DW'($urandom), (i == 3), 1'b0);
            check_state("reload");
        end
        tick();
        check_state("reload_plus1");
        for (int i = 0; i < 4; i++) rd_chk("reload_rd", i);

        // Full image without load_last stops at the last address
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) load_byte(DW'($urandom), 1'b0, 1'b0);
        check_state("full_run");
        chk("full_words", 32'(words_loaded), 32'(DEPTH));
        b = m_mem[0];
        load_byte(~b, 1'b0, 1'b0);
        check_state("full_65th");
        rd_chk("full_mem0", 0);
        for (int i = 1; i < DEPTH; i += 9) rd_chk("full_rd", i);

        // Skip alongside a transfer still writes the byte
        do_reset(1);
        load_byte(8'h5C, 1'b0, 1'b1);
        check_state("skip_xfer");
        tick();
        rd_chk("skip_xfer_mem0", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter ADR_W, default 6, meaning memory address width (depth = 2**ADR_W words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning memory word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port adr_bus, input, ADR_W, CPU address.
REQ-006 SHALL have port rd_mem, input, 1, CPU read strobe.
REQ-007 SHALL have port wr_mem, input, 1, CPU write strobe.
REQ-008 SHALL have port data_bus, inout, DATA_W, shared CPU data bus.
REQ-009 SHALL have port load_valid, input, 1, loader byte present.
REQ-010 SHALL have port load_data, input, DATA_W, loader byte.
REQ-011 SHALL have port load_last, input, 1, marks final loader byte; qualified by load_valid.
REQ-012 SHALL have port load_skip, input, 1, leave LOAD without writing (rerun existing image).
REQ-013 SHALL have port load_ready, output, 1, block accepts a loader byte this cycle.
REQ-014 SHALL have port cpu_reset, output, 1, holds downstream CPU in reset.
REQ-015 SHALL have port words_loaded, output, ADR_W+1, count of bytes written in current LOAD.
REQ-016 SHALL have port bus_err, output, 1, sticky flag: rd_mem and wr_mem both high in RUN.

Function
REQ-017 SHALL implement two states, LOAD and RUN; reset enters LOAD.
REQ-018 In LOAD: load_ready=1, cpu_reset=1, data_bus high-Z, rd_mem/wr_mem ignored.
REQ-019 In LOAD, a transfer SHALL occur when load_valid&load_ready; it writes load_data to mem[load_adr] on that edge, then load_adr and words_loaded increment by 1.
REQ-020 LOAD->RUN on the edge of a transfer with load_last=1, or when the transfer writes address 2**ADR_W-1 (full; no wrap, no further writes), or on any edge with load_skip=1 and no transfer.
REQ-021 load_skip together with a transfer: the byte SHALL be written first, then RUN.
REQ-022 In RUN: load_ready=0, cpu_reset=0; loader inputs ignored; state remains RUN until reset.
REQ-023 In RUN with rd_mem=1: data_bus SHALL be driven combinationally with mem[adr_bus] (zero wait states); otherwise high-Z.
REQ-024 In RUN with wr_mem=1 and rd_mem=0: mem[adr_bus] <= data_bus on the rising edge.
REQ-025 In RUN with rd_mem=wr_mem=1: read drive wins, write suppressed, bus_err set and held until reset.
REQ-026 cpu_reset SHALL be registered and deassert exactly one cycle after RUN is entered, so the CPU sees one full reset cycle after the final load write.

Reset
REQ-027 On reset: state=LOAD, load_adr=0, words_loaded=0, bus_err=0, cpu_reset=1, load_ready=1, data_bus high-Z.
REQ-028 Reset SHALL NOT clear memory contents; reset mid-LOAD restarts loading at address 0; reset mid-RUN returns to LOAD with the image retained (load_skip reuses it).

Structure
REQ-029 A shared package SHALL hold ADR_W/DATA_W defaults and the LOAD/RUN state enum.
REQ-030 Storage SHALL be one sub-module, mem_array, with one synchronous write port and one asynchronous read port; the write port is muxed between loader and CPU by state.

Verification
REQ-031 Reset, load 3 bytes 0x11,0x22,0x33 with load_last on 3rd -> words_loaded=3, RUN entered, cpu_reset low one cycle later; rd_mem adr 2 -> data_bus=0x33.
REQ-032 Load 64 bytes without load_last -> RUN after byte 64, words_loaded=64, 65th load_valid ignored, mem[0] unchanged.
REQ-033 In RUN, wr_mem adr 5 data 0xA5, next cycle rd_mem adr 5 -> 0xA5; with no strobe, data_bus high-Z.
REQ-034 In RUN, rd_mem=wr_mem=1 adr 2 data 0xFF -> data_bus=0x33, mem[2] unchanged, bus_err=1 until reset.
REQ-035 Reset mid-RUN then load_skip -> RUN with words_loaded=0 and mem[0]=0x11 readable.
REQ-036 Reset after 2 of 4 loader bytes -> loading resumes at address 0, cpu_reset stays high throughout.
